// File: rtl/pmem_burst_adapter.sv
// Bridges 256-bit L2 line requests onto a 4-beat, 64-bit memory burst bus.
// The read line is assembled in a private buffer and published to pmem_rdata only on completion.
module pmem_burst_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [31:0]          pmem_address,
  input  logic [LINE_W-1:0]    pmem_wdata,
  output logic [LINE_W-1:0]    pmem_rdata,
  output logic                 pmem_resp,
  output logic                 burst_read,
  output logic                 burst_write,
  output logic [31:0]          burst_address,
  output logic [BURST_W-1:0]   burst_wdata,
  input  logic [BURST_W-1:0]   burst_rdata,
  input  logic                 burst_resp,
  output logic [1:0]           dbg_state
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BEAT_W-1:0]   beat_nxt;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [LINE_W-1:0]   rdata_q, rdata_d;
  logic [BURST_W-1:0]  bwdata_q, bwdata_d;
  logic                resp_q, resp_d;
  logic                bread_q, bread_d;
  logic                bwrite_q, bwrite_d;

  // Handshake: the L2 holds pmem_read/pmem_write until a one-cycle pmem_resp;
  // each cycle burst_resp is high while a burst request is up moves exactly one beat.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    bwdata_d = bwdata_q;
    resp_d   = 1'b0;
    bread_d  = 1'b0;
    bwrite_d = 1'b0;
    beat_nxt = beat_q + BEAT_W'(1);

    case (state_q)
      S_IDLE: begin
        beat_d = '0;
        // Write has priority when the L2 raises both requests.
        if (pmem_write) begin
          state_d  = S_WRITE;
          addr_d   = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
          wdata_d  = pmem_wdata;
          bwdata_d = pmem_wdata[BURST_W-1:0];
          bwrite_d = 1'b1;
        end else if (pmem_read) begin
          state_d  = S_READ;
          addr_d   = {pmem_address[31:OFF_W], {OFF_W{1'b0}}};
          bread_d  = 1'b1;
        end
      end

      S_READ: begin
        bread_d = 1'b1;
        if (burst_resp) begin
          line_d[beat_q*BURST_W +: BURST_W] = burst_rdata;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
            beat_d  = '0;
            bread_d = 1'b0;
            resp_d  = 1'b1;
            rdata_d = line_d;
          end else begin
            beat_d = beat_nxt;
          end
        end
      end

      S_WRITE: begin
        bwrite_d = 1'b1;
        if (burst_resp) begin
          if (beat_q == LAST_BEAT) begin
            state_d  = S_DONE;
            beat_d   = '0;
            bwrite_d = 1'b0;
            resp_d   = 1'b1;
            bwdata_d = '0;
          end else begin
            beat_d   = beat_nxt;
            bwdata_d = wdata_q[beat_nxt*BURST_W +: BURST_W];
          end
        end
      end

      // A request still held here belongs to the transaction just finished.
      S_DONE: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end

      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      line_q   <= '0;
      rdata_q  <= '0;
      bwdata_q <= '0;
      resp_q   <= 1'b0;
      bread_q  <= 1'b0;
      bwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      line_q   <= line_d;
      rdata_q  <= rdata_d;
      bwdata_q <= bwdata_d;
      resp_q   <= resp_d;
      bread_q  <= bread_d;
      bwrite_q <= bwrite_d;
    end
  end

  assign pmem_rdata    = rdata_q;
  assign pmem_resp     = resp_q;
  assign burst_read    = bread_q;
  assign burst_write   = bwrite_q;
  assign burst_address = addr_q;
  assign burst_wdata   = bwdata_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed and randomized line transactions against a line-level model of the burst adapter.
module tb_pmem_burst_adapter;

  localparam logic [1:0] ST_IDLE = 2'd0;

  logic          clk;
  logic          rst;
  logic          pmem_read;
  logic          pmem_write;
  logic [31:0]   pmem_address;
  logic [255:0]  pmem_wdata;
  logic [255:0]  pmem_rdata;
  logic          pmem_resp;
  logic          burst_read;
  logic          burst_write;
  logic [31:0]   burst_address;
  logic [63:0]   burst_wdata;
  logic [63:0]   burst_rdata;
  logic          burst_resp;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int resp_seen = 0;
  int resp_exp = 0;

  logic [63:0]  exp_q[$];
  bit           ack_q[$];
  logic [255:0] last_rline;

  pmem_burst_adapter dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_address  (pmem_address),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_address (burst_address),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_resp    (burst_resp),
    .dbg_state     (dbg_state)
  );

  // Clock and cycle bookkeeping.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pmem_resp === 1'b1) resp_seen <= resp_seen + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles from the accept cycle to pmem_resp inclusive: accept + burst cycles up to 4th ack + done.
  function automatic int exp_latency();
    int ones = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= ack_q.size() || ack_q[i]) ones++;
      if (ones == 4) return i + 3;
    end
    return -1;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  // One complete L2 transaction; rline supplies the beats a memory would return, slice k on beat k.
  task automatic do_txn(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] rline);
    bit           is_wr;
    bit           r;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata;
    int           acks;
    int           bcyc;
    int           c0;
    int           wait_n;
    int           lat_exp;
    is_wr    = wr;
    exp_addr = {addr[31:5], 5'b0};
    lat_exp  = exp_latency();
    acks     = 0;
    bcyc     = 0;
    exp_q.delete();
    if (is_wr) for (int k = 0; k < 4; k++) exp_q.push_back(wline[k*64 +: 64]);
    exp_rdata = is_wr ? last_rline : rline;

    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wline;
    burst_resp   = 1'b1;
    burst_rdata  = {$urandom, $urandom};
    c0 = cyc;
    @(posedge clk);

    while (acks < 4 && bcyc < 64) begin
      @(negedge clk);
      pmem_address = $urandom;
      pmem_wdata   = rand_line();
      r = (bcyc < ack_q.size()) ? ack_q[bcyc] : 1'b1;
      burst_resp  = r;
      burst_rdata = r ? rline[acks*64 +: 64] : {$urandom, $urandom};
      chk("burst_read", 256'(burst_read), 256'(!is_wr));
      chk("burst_write", 256'(burst_write), 256'(is_wr));
      chk("burst_address", 256'(burst_address), 256'(exp_addr));
      chk("resp_early", 256'(pmem_resp), 256'(1'b0));
      if (is_wr) begin
        if (exp_q.size() == 0) chk("wdata_queue", 256'(1'b1), 256'(1'b0));
        else begin
          chk("burst_wdata", 256'(burst_wdata), 256'(exp_q[0]));
          if (r) void'(exp_q.pop_front());
        end
      end
      @(posedge clk);
      bcyc++;
      if (r) acks++;
    end

    @(negedge clk);
    burst_resp  = 1'b1;
    burst_rdata = {$urandom, $urandom};
    wait_n = 0;
    while (pmem_resp !== 1'b1 && wait_n < 8) begin
      @(posedge clk);
      @(negedge clk);
      wait_n++;
    end
    chk("pmem_resp", 256'(pmem_resp), 256'(1'b1));
    chk("latency", 256'(cyc - c0 + 1), 256'(lat_exp));
    chk("done_burst_read", 256'(burst_read), 256'(1'b0));
    chk("done_burst_write", 256'(burst_write), 256'(1'b0));
    chk("pmem_rdata", pmem_rdata, exp_rdata);
    resp_exp++;
    if (!is_wr) last_rline = rline;

    // Request is still high through the done cycle; it drops one cycle later.
    @(posedge clk);
    @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    burst_resp = 1'b0;
    chk("resp_single", 256'(pmem_resp), 256'(1'b0));
    chk("no_reaccept_rd", 256'(burst_read), 256'(1'b0));
    chk("no_reaccept_wr", 256'(burst_write), 256'(1'b0));
    chk("idle_state", 256'(dbg_state), 256'(ST_IDLE));
    chk("rdata_hold", pmem_rdata, last_rline);
  endtask

  initial begin
    logic [255:0] l;
    bit pat[7];
    int kind;

    rst          = 1'b1;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_resp   = 1'b0;
    last_rline   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst         = 1'b0;
    burst_resp  = 1'b1;
    burst_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    burst_resp = 1'b0;
    chk("rst_state", 256'(dbg_state), 256'(ST_IDLE));
    chk("rst_resp", 256'(pmem_resp), 256'(1'b0));
    chk("rst_burst_read", 256'(burst_read), 256'(1'b0));
    chk("rst_burst_write", 256'(burst_write), 256'(1'b0));
    chk("rst_burst_address", 256'(burst_address), 256'(32'h0));
    chk("rst_burst_wdata", 256'(burst_wdata), 256'(64'h0));
    chk("rst_pmem_rdata", pmem_rdata, 256'h0);

    // Back-to-back read with continuous acks.
    ack_q.delete();
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_txn(1'b1, 1'b0, 32'h0000_1234, '0, l);

    // Write line delivered low slice first.
    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    do_txn(1'b0, 1'b1, 32'h0000_4567, l, '0);

    // Stalled read.
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    ack_q.delete();
    foreach (pat[i]) ack_q.push_back(pat[i]);
    do_txn(1'b1, 1'b0, 32'hABCD_EF1F, '0, rand_line());

    // Both requests high: write wins.
    ack_q.delete();
    do_txn(1'b1, 1'b1, 32'h1000_0020, rand_line(), rand_line());

    // Reset after two read beats.
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 32'h0000_8040;
    burst_resp   = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      @(posedge clk);
    end
    @(negedge clk);
    chk("midrst_active", 256'(burst_read), 256'(1'b1));
    rst         = 1'b1;
    pmem_read   = 1'b0;
    burst_resp  = 1'b1;
    burst_rdata = {$urandom, $urandom};
    @(posedge clk);
    @(negedge clk);
    rst        = 1'b0;
    burst_resp = 1'b0;
    last_rline = '0;
    chk("midrst_burst_read", 256'(burst_read), 256'(1'b0));
    chk("midrst_state", 256'(dbg_state), 256'(ST_IDLE));
    chk("midrst_resp", 256'(pmem_resp), 256'(1'b0));
    chk("midrst_rdata", pmem_rdata, 256'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_resp", 256'(pmem_resp), 256'(1'b0));
    end
    do_txn(1'b1, 1'b0, 32'h0000_8040, '0, rand_line());

    // Read then write, request reasserted.
    do_txn(1'b1, 1'b0, 32'h0001_0000, '0, rand_line());
    do_txn(1'b0, 1'b1, 32'h0001_0020, rand_line(), '0);

    // Randomized transactions with random stall patterns.
    for (int t = 0; t < 24; t++) begin
      ack_q.delete();
      for (int i = 0; i < 12; i++) ack_q.push_back($urandom_range(0, 99) < 60);
      kind = $urandom_range(0, 2);
      do_txn(kind != 1, kind != 0, $urandom, rand_line(), rand_line());
    end

    @(posedge clk);
    @(negedge clk);
    chk("resp_count", 256'(resp_seen), 256'(resp_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
